// File: rtl/led_rot_pkg.sv
// led_rot_pkg: shared state enum, direction constants and default sizes for the LED ring decoder
package led_rot_pkg;
  typedef enum logic [1:0] {IDLE, LOCKED, ERROR} state_e;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/onehot_enc.sv
// onehot_enc: combinational one-hot to index encoder with an exactly-one-bit-set flag
//   vec_i   [WIDTH-1:0]      pattern to encode
//   idx_o   [$clog2(WIDTH)]  index of the set bit (OR of set indices when illegal)
//   legal_o                  high when exactly one bit of vec_i is set
module onehot_enc #(
  parameter int WIDTH = 16,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IW-1:0]    idx_o,
  output logic             legal_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++)
      if (vec_i[i]) idx_o = idx_o | IW'(i);
  end
  // non-zero and clearing the lowest set bit leaves nothing
  assign legal_o = (|vec_i) && ~|(vec_i & (vec_i - WIDTH'(1)));
endmodule

// File: rtl/led_rot_decoder.sv
// led_rot_decoder: tracks position, direction and step/revolution counts of a rotating one-hot LED ring
//   clk, rst_n          clock, asynchronous active-low reset
//   led_in [WIDTH]      ring pattern, sampled when sample_en is high
//   sample_en           sample strobe
//   clr                 synchronous clear of counters and lock (wins over sample_en)
//   pos                 index of the lit bit, valid while locked
//   valid / err         locked / error state flags
//   dir_out, moving     last step direction (1 = index+1), last sample was a single step
//   step_cnt, rev_cnt   saturating step and revolution counters
//   wrap                one-cycle pulse on a step across the WIDTH-1/0 boundary
// Optional: define LED_ROT_REV_CNT_EN to build the revolution counter; otherwise rev_cnt is 0.
module led_rot_decoder
  import led_rot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  localparam int PW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] led_in,
  input  logic             sample_en,
  input  logic             clr,
  output logic [PW-1:0]    pos,
  output logic             valid,
  output logic             dir_out,
  output logic             moving,
  output logic [CNT_W-1:0] step_cnt,
  output logic [CNT_W-1:0] rev_cnt,
  output logic             wrap,
  output logic             err
);
  state_e           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d, idx, delta;
  logic             dir_q, dir_d, moving_q, moving_d, wrap_q, wrap_d, legal;
  logic [CNT_W-1:0] step_q, step_d;
  logic             step_up, step_dn;
  onehot_enc #(.WIDTH(WIDTH)) u_enc (.vec_i(led_in), .idx_o(idx), .legal_o(legal));
  // modular distance from the held position to the new one
  assign delta = idx - pos_q;
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    moving_d = moving_q;
    step_d   = step_q;
    wrap_d   = 1'b0;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      step_d  = '0;
    end else if (sample_en) begin
      moving_d = 1'b0;
      if (!legal) begin
        state_d = ERROR;
      end else if (state_q != LOCKED) begin
        state_d = LOCKED;
        pos_d   = idx;
      end else if (delta == PW'(1) || delta == '1) begin
        step_up  = delta == PW'(1);
        step_dn  = !step_up;
        pos_d    = idx;
        dir_d    = step_up ? DIR_UP : DIR_DN;
        moving_d = 1'b1;
        step_d   = (step_q != '1) ? step_q + CNT_W'(1) : step_q;
        wrap_d   = step_up ? (pos_q == '1) : (pos_q == '0);
      end else if (delta != '0) begin
        state_d = ERROR;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      moving_q <= 1'b0;
      step_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
    end
  end
`ifdef LED_ROT_REV_CNT_EN
  // seen_q: dir_q comes from a real step; dirty_q: direction flipped since the last wrap
  logic [CNT_W-1:0] rev_q, rev_d;
  logic             seen_q, seen_d, dirty_q, dirty_d, flip;
  assign flip = seen_q && (step_up != dir_q);
  always_comb begin
    rev_d   = rev_q;
    seen_d  = seen_q;
    dirty_d = dirty_q;
    if (clr) begin
      rev_d   = '0;
      seen_d  = 1'b0;
      dirty_d = 1'b0;
    end else if (step_up || step_dn) begin
      seen_d  = 1'b1;
      dirty_d = wrap_d ? 1'b0 : (dirty_q || flip);
      rev_d   = (wrap_d && !dirty_q && !flip && rev_q != '1) ? rev_q + CNT_W'(1) : rev_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_q   <= '0;
      seen_q  <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      rev_q   <= rev_d;
      seen_q  <= seen_d;
      dirty_q <= dirty_d;
    end
  end
  assign rev_cnt = rev_q;
`else
  assign rev_cnt = '0;
`endif
  assign pos      = pos_q;
  assign valid    = state_q == LOCKED;
  assign err      = state_q == ERROR;
  assign dir_out  = dir_q;
  assign moving   = moving_q;
  assign step_cnt = step_q;
  assign wrap     = wrap_q;
endmodule

// File: tb/tb_led_rot_decoder.sv
// tb_led_rot_decoder: directed self-checking bench for led_rot_decoder
module tb_led_rot_decoder;
  logic        clk = 1'b0, rst_n = 1'b0, sample_en = 1'b0, clr = 1'b0;
  logic [15:0] led_in = '0;
  logic [3:0]  pos;
  logic        valid, dir_out, moving, wrap, err;
  logic [7:0]  step_cnt, rev_cnt;
  int tests = 0, fails = 0;
  led_rot_decoder dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .sample_en(sample_en), .clr(clr),
    .pos(pos), .valid(valid), .dir_out(dir_out), .moving(moving),
    .step_cnt(step_cnt), .rev_cnt(rev_cnt), .wrap(wrap), .err(err)
  );
  always #5 clk = ~clk;
  task automatic smp(input logic [15:0] p);
    led_in = p;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask
  task automatic idle();
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if ({pos, valid, dir_out, moving, step_cnt, rev_cnt, wrap, err} !== 28'h0) begin
      fails++; $display("FAIL reset_outputs got pos=%0d valid=%b dir=%b mov=%b step=%0d rev=%0d wrap=%b err=%b want all 0", pos, valid, dir_out, moving, step_cnt, rev_cnt, wrap, err);
    end
    rst_n = 1'b1;
    idle();
  endtask
  task automatic test_lock();
    smp(16'h8000);
    tests++; if ({valid, pos, step_cnt, moving, err} !== {1'b1, 4'd15, 8'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL lock got valid=%b pos=%0d step=%0d mov=%b err=%b want 1 15 0 0 0", valid, pos, step_cnt, moving, err);
    end
  endtask
  task automatic test_rotate_up();
    smp(16'h0001);
    tests++; if ({pos, dir_out, moving, wrap, step_cnt} !== {4'd0, 1'b1, 1'b1, 1'b1, 8'd1}) begin
      fails++; $display("FAIL up_wrap got pos=%0d dir=%b mov=%b wrap=%b step=%0d want 0 1 1 1 1", pos, dir_out, moving, wrap, step_cnt);
    end
    smp(16'h0002);
    tests++; if ({pos, dir_out, wrap, step_cnt} !== {4'd1, 1'b1, 1'b0, 8'd2}) begin
      fails++; $display("FAIL up_step got pos=%0d dir=%b wrap=%b step=%0d want 1 1 0 2", pos, dir_out, wrap, step_cnt);
    end
    idle();
    tests++; if ({pos, moving, wrap, step_cnt} !== {4'd1, 1'b1, 1'b0, 8'd2}) begin
      fails++; $display("FAIL hold_no_sample got pos=%0d mov=%b wrap=%b step=%0d want 1 1 0 2", pos, moving, wrap, step_cnt);
    end
  endtask
  task automatic test_rotate_dn();
    smp(16'h0001);
    tests++; if ({pos, dir_out, wrap, step_cnt} !== {4'd0, 1'b0, 1'b0, 8'd3}) begin
      fails++; $display("FAIL dn_step got pos=%0d dir=%b wrap=%b step=%0d want 0 0 0 3", pos, dir_out, wrap, step_cnt);
    end
    smp(16'h8000);
    tests++; if ({pos, dir_out, wrap, step_cnt} !== {4'd15, 1'b0, 1'b1, 8'd4}) begin
      fails++; $display("FAIL dn_wrap got pos=%0d dir=%b wrap=%b step=%0d want 15 0 1 4", pos, dir_out, wrap, step_cnt);
    end
    smp(16'h8000);
    tests++; if ({pos, dir_out, moving, wrap, step_cnt} !== {4'd15, 1'b0, 1'b0, 1'b0, 8'd4}) begin
      fails++; $display("FAIL same_sample got pos=%0d dir=%b mov=%b wrap=%b step=%0d want 15 0 0 0 4", pos, dir_out, moving, wrap, step_cnt);
    end
  endtask
  task automatic test_jump();
    smp(16'h0001); smp(16'h0002); smp(16'h0004); smp(16'h0008);
    tests++; if ({pos, step_cnt, valid} !== {4'd3, 8'd8, 1'b1}) begin
      fails++; $display("FAIL pre_jump got pos=%0d step=%0d valid=%b want 3 8 1", pos, step_cnt, valid);
    end
    smp(16'h0040);
    tests++; if ({err, valid, pos, step_cnt} !== {1'b1, 1'b0, 4'd3, 8'd8}) begin
      fails++; $display("FAIL jump_err got err=%b valid=%b pos=%0d step=%0d want 1 0 3 8", err, valid, pos, step_cnt);
    end
    smp(16'h0040);
    tests++; if ({err, valid, pos, step_cnt, moving} !== {1'b0, 1'b1, 4'd6, 8'd8, 1'b0}) begin
      fails++; $display("FAIL relock got err=%b valid=%b pos=%0d step=%0d mov=%b want 0 1 6 8 0", err, valid, pos, step_cnt, moving);
    end
  endtask
  task automatic test_illegal_clr();
    smp(16'h0000);
    tests++; if ({err, valid} !== 2'b10) begin
      fails++; $display("FAIL zero_pattern got err=%b valid=%b want 1 0", err, valid);
    end
    smp(16'h0003);
    tests++; if ({err, valid} !== 2'b10) begin
      fails++; $display("FAIL multi_bit got err=%b valid=%b want 1 0", err, valid);
    end
    clr = 1'b1;
    smp(16'h0001);
    clr = 1'b0;
    tests++; if ({err, valid, step_cnt, rev_cnt} !== {1'b0, 1'b0, 8'd0, 8'd0}) begin
      fails++; $display("FAIL clr got err=%b valid=%b step=%0d rev=%0d want 0 0 0 0", err, valid, step_cnt, rev_cnt);
    end
    idle();
    tests++; if ({err, valid} !== 2'b00) begin
      fails++; $display("FAIL clr_discard got err=%b valid=%b want 0 0", err, valid);
    end
  endtask
  task automatic test_count();
    logic [7:0] rev_exp;
    smp(16'h0001);
    for (int k = 1; k <= 32; k++) smp(16'h0001 << (k % 16));
`ifdef LED_ROT_REV_CNT_EN
    rev_exp = 8'd2;
`else
    rev_exp = 8'd0;
`endif
    tests++; if ({step_cnt, rev_cnt, pos} !== {8'd32, rev_exp, 4'd0}) begin
      fails++; $display("FAIL rev32 got step=%0d rev=%0d pos=%0d want 32 %0d 0", step_cnt, rev_cnt, pos, rev_exp);
    end
    for (int k = 1; k <= 240; k++) smp(16'h0001 << (k % 16));
`ifdef LED_ROT_REV_CNT_EN
    rev_exp = 8'd17;
`endif
    tests++; if ({step_cnt, rev_cnt, pos, moving} !== {8'd255, rev_exp, 4'd0, 1'b1}) begin
      fails++; $display("FAIL step_sat got step=%0d rev=%0d pos=%0d mov=%b want 255 %0d 0 1", step_cnt, rev_cnt, pos, moving, rev_exp);
    end
  endtask
  task automatic test_async_reset_reversal();
    logic [7:0] rev_exp;
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({valid, step_cnt, pos, err} !== {1'b0, 8'd0, 4'd0, 1'b0}) begin
      fails++; $display("FAIL async_reset got valid=%b step=%0d pos=%0d err=%b want 0 0 0 0", valid, step_cnt, pos, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    smp(16'h0001);
    smp(16'h0002); smp(16'h0004); smp(16'h0008);
    smp(16'h0004); smp(16'h0002); smp(16'h0001); smp(16'h8000);
    tests++; if ({pos, dir_out, wrap, rev_cnt, step_cnt} !== {4'd15, 1'b0, 1'b1, 8'd0, 8'd7}) begin
      fails++; $display("FAIL reverse_wrap got pos=%0d dir=%b wrap=%b rev=%0d step=%0d want 15 0 1 0 7", pos, dir_out, wrap, rev_cnt, step_cnt);
    end
    for (int k = 14; k >= -1; k--) smp(16'h0001 << (k & 15));
`ifdef LED_ROT_REV_CNT_EN
    rev_exp = 8'd1;
`else
    rev_exp = 8'd0;
`endif
    tests++; if ({pos, rev_cnt, step_cnt, valid, err} !== {4'd15, rev_exp, 8'd23, 1'b1, 1'b0}) begin
      fails++; $display("FAIL dn_rev got pos=%0d rev=%0d step=%0d valid=%b err=%b want 15 %0d 23 1 0", pos, rev_cnt, step_cnt, valid, err, rev_exp);
    end
  endtask
  initial begin
    test_reset();
    test_lock();
    test_rotate_up();
    test_rotate_dn();
    test_jump();
    test_illegal_clr();
    test_count();
    test_async_reset_reversal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
